// File: rtl/hack_cpu_core.sv
// rtl/hack_cpu_core.sv - Hack-style single-cycle CPU datapath, control and internal ALU

// Combinational 16-bit Hack ALU: zero/negate each operand, add or AND, optionally negate result.
module hack_cpu_alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);

  logic [15:0] x_z, x_n, y_z, y_n, fn_out;

  // Operand preconditioning, function select and output conditioning.
  always_comb begin
    x_z    = zx ? 16'h0000 : x;
    x_n    = nx ? ~x_z : x_z;
    y_z    = zy ? 16'h0000 : y;
    y_n    = ny ? ~y_z : y_z;
    fn_out = f ? (x_n + y_n) : (x_n & y_n);
    out    = no ? ~fn_out : fn_out;
    zr     = (out == 16'h0000);
    ng     = out[15];
  end

endmodule

// CPU core: decodes instruction, drives ALU, holds A/D/PC.
module hack_cpu_core #(
  parameter int PC_WIDTH = 15,
  parameter int RESET_PC = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [15:0]         instruction,
  input  logic [15:0]         inM,
  output logic [15:0]         outM,
  output logic                writeM,
  output logic [PC_WIDTH-1:0] addressM,
  output logic [PC_WIDTH-1:0] pc
);

  logic [15:0]         a_reg;
  logic [15:0]         d_reg;
  logic [PC_WIDTH-1:0] pc_reg;

  logic                is_c;
  logic                sel_m;
  logic                dest_a, dest_d, dest_m;
  logic                j_lt, j_eq, j_gt;
  logic [15:0]         alu_y;
  logic [15:0]         alu_out;
  logic                alu_zr, alu_ng;
  logic                jump_taken;
  logic [PC_WIDTH-1:0] pc_inc;
  logic                unused_fill_bits;

  // Field decode; bits 14:13 of a C-instruction carry no meaning.
  always_comb begin
    is_c             = instruction[15];
    sel_m            = instruction[12];
    dest_a           = instruction[5];
    dest_d           = instruction[4];
    dest_m           = instruction[3];
    j_lt             = instruction[2];
    j_eq             = instruction[1];
    j_gt             = instruction[0];
    unused_fill_bits = ^instruction[14:13];
  end

  assign alu_y = sel_m ? inM : a_reg;

  hack_cpu_alu u_alu (
    .x   (d_reg),
    .y   (alu_y),
    .zx  (instruction[11]),
    .nx  (instruction[10]),
    .zy  (instruction[9]),
    .ny  (instruction[8]),
    .f   (instruction[7]),
    .no  (instruction[6]),
    .out (alu_out),
    .zr  (alu_zr),
    .ng  (alu_ng)
  );

  // Jump condition and next-sequential PC (wraps modulo 2^PC_WIDTH).
  always_comb begin
    jump_taken = is_c & ((j_lt & alu_ng) | (j_eq & alu_zr) | (j_gt & ~alu_ng & ~alu_zr));
    pc_inc     = pc_reg + PC_WIDTH'(1);
  end

  assign outM     = alu_out;
  assign writeM   = is_c & dest_m & ~reset;
  assign addressM = a_reg[PC_WIDTH-1:0];
  assign pc       = pc_reg;

  // Architectural state update; jump target is the pre-edge A even if A is also written.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_reg  <= 16'h0000;
      d_reg  <= 16'h0000;
      pc_reg <= PC_WIDTH'(RESET_PC);
    end else begin
      if (!is_c) begin
        a_reg <= instruction;
      end else begin
        if (dest_a) a_reg <= alu_out;
        if (dest_d) d_reg <= alu_out;
      end
      pc_reg <= jump_taken ? a_reg[PC_WIDTH-1:0] : pc_inc;
    end
  end

endmodule
